oh_txgear: RTL and testbench
============================

# oh_txgear

Transmit gearbox that sits directly upstream of the 8:1 output serializer. It accepts PW-bit words over a valid/ready handshake and presents one 8-bit parallel word per clk (the serializer's slow-clock domain), LSB byte first. It inserts a fixed training pattern after enable and an idle pattern whenever no data is available. tx_data[0] is the bit the serializer shifts out first.

## Interface
- PW, 32, input word width; multiple of 8, range 8..64; NB = PW/8 bytes per word
- TRAIN_CYCLES, 64, number of clk cycles of training pattern after enable; range 1..255
- TRAIN_WORD, 8'hA5, byte driven during training
- IDLE_WORD, 8'h00, byte driven when idle or disabled

- clk  in  1  serializer parallel (divided) clock; all logic on rising edge
- nreset  in  1  asynchronous, active-low reset
- enable  in  1  link enable, level-sensitive
- in_valid  in  1  in_data is valid
- in_data  in  PW  word to transmit; byte 0 = in_data[7:0]
- in_ready  out  1  block accepts in_data this cycle
- tx_data  out  8  parallel byte to serializer (D1 = tx_data[0])
- tx_frame  out  1  high when tx_data carries payload
- train_done  out  1  training complete, link usable

## Operation
- States: OFF, TRAIN, IDLE, SEND. Byte counter bcnt (clog2(NB) bits, min 1). Training counter tcnt (8 bits).
- OFF: tx_data=IDLE_WORD, tx_frame=0, train_done=0. enable=1 -> TRAIN, tcnt cleared.
- TRAIN: tx_data=TRAIN_WORD, tx_frame=0, in_ready=0. After TRAIN_CYCLES cycles of TRAIN_WORD -> IDLE, train_done=1.
- IDLE: in_ready=1. Transfer (in_valid & in_ready) latches in_data -> SEND, bcnt=0. No transfer: tx_data=IDLE_WORD, tx_frame=0.
- SEND: tx_data=byte[bcnt], tx_frame=1, bcnt increments. in_ready=1 only during the cycle byte NB-1 is presented. A transfer in that cycle reloads the word and restarts at byte 0, giving a gapless stream. No transfer -> IDLE.
- NB=1: in_ready=1 every SEND cycle.
- in_ready = 0 whenever enable=0 or state is OFF/TRAIN. in_ready is combinational from state, bcnt and enable. It never depends on in_valid.
- enable=0 in any state -> OFF on the next edge. Any in-flight word is dropped and train_done clears. Re-enable always retrains.
- in_data is sampled only on transfer; the caller may change it freely otherwise.

## Timing
- Reset (nreset=0): state=OFF, tx_data=8'h00, tx_frame=0, train_done=0, in_ready=0, counters 0. Reset is asserted asynchronously and released on clk.
- tx_data, tx_frame and train_done are registered.
- Transfer at edge k: byte 0 appears after edge k, byte j appears after edge k+j. Last byte appears after edge k+NB-1.
- Sustained throughput: one word per NB cycles, with zero idle bytes between back-to-back words.
- enable rises before edge e: TRAIN_WORD appears from after edge e+1. train_done rises after edge e+TRAIN_CYCLES+1, together with the first IDLE_WORD. in_ready rises in the same cycle.
- enable falls before edge f: after edge f, outputs are IDLE_WORD, tx_frame=0, train_done=0.
- Reset asserted mid-word: outputs go to their reset values immediately, with no partial bytes afterwards.

## Configuration
- OH_TXGEAR_TRAIN_EN defined: TRAIN state present, behaviour as above.
- Not defined: TRAIN state and tcnt are removed, and TRAIN_CYCLES and TRAIN_WORD are unused. enable=1 moves OFF -> IDLE in one edge. train_done rises together with that transition, and in_ready is high in the following cycle.

## Test plan
- Reset, then enable=1 with training compiled in (PW=32, TRAIN_CYCLES=4) -> exactly 4 cycles of 8'hA5, tx_frame=0. train_done and in_ready rise with the first 8'h00.
- Single word 32'h44332211 accepted in IDLE -> tx_data 11,22,33,44 on consecutive cycles with tx_frame=1. Then 8'h00 with tx_frame=0.
- Back-to-back words 32'h04030201, 32'h08070605 with in_valid held high -> 01..08 with no gap. in_ready pulses once per 4 cycles, on the byte-3 cycle.
- Drop enable after byte 1 of a word -> next cycle 8'h00, tx_frame=0, train_done=0. Re-enable -> full training again before in_ready=1.
- Assert nreset mid-SEND -> all outputs 0 asynchronously. After release with enable=1, the training sequence restarts.
- Build without OH_TXGEAR_TRAIN_EN, PW=8 -> train_done one cycle after enable, no 8'hA5 ever. in_ready is high on every SEND cycle, and a byte stream 0x5A,0xC3 appears one per cycle.

Source files
------------

// File: rtl/oh_txgear.sv
// rtl/oh_txgear.sv - transmit gearbox feeding an 8:1 output serializer
//
// Purpose:
//   Accepts PW-bit words over a valid/ready handshake and emits one byte per
//   clk, LSB byte first, to the serializer's parallel input. After enable it
//   sends TRAIN_CYCLES bytes of TRAIN_WORD, then IDLE_WORD whenever no payload
//   is available.
//
// Configuration macro:
//   OH_TXGEAR_TRAIN_EN - when defined, the TRAIN state and its counter are
//   built. When undefined, enable takes the link straight from OFF to IDLE,
//   and TRAIN_CYCLES / TRAIN_WORD have no effect.
//
// Ports:
//   clk         serializer parallel (divided) clock, rising edge
//   nreset      asynchronous active-low reset
//   enable      link enable, level-sensitive; low forces OFF
//   in_valid    in_data holds a word to send
//   in_data     PW-bit word; byte 0 = in_data[7:0] goes out first
//   in_ready    word accepted this cycle (combinational, never from in_valid)
//   tx_data     parallel byte to serializer, tx_data[0] shifted first
//   tx_frame    tx_data carries payload
//   train_done  training finished, link usable

module oh_txgear #(
   parameter int         PW           = 32,
   parameter int         TRAIN_CYCLES = 64,
   parameter logic [7:0] TRAIN_WORD   = 8'hA5,
   parameter logic [7:0] IDLE_WORD    = 8'h00
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          enable,
   input  logic          in_valid,
   input  logic [PW-1:0] in_data,
   output logic          in_ready,
   output logic [7:0]    tx_data,
   output logic          tx_frame,
   output logic          train_done
);

   localparam int            NB   = PW / 8;
   localparam int            BW   = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] LAST = BW'(NB - 1);

`ifdef OH_TXGEAR_TRAIN_EN
   typedef enum logic [1:0] {S_OFF, S_TRAIN, S_IDLE, S_SEND} state_t;
   localparam logic [7:0] TC = 8'(TRAIN_CYCLES);
   logic [7:0] tcnt_q, tcnt_d;
`else
   typedef enum logic [1:0] {S_OFF, S_IDLE, S_SEND} state_t;
   wire unused_train_cfg = ^{TRAIN_WORD, 8'(TRAIN_CYCLES)};
`endif

   state_t          state_q, state_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   // Bytes of the current word not yet presented; byte bcnt+1 sits at [7:0].
   logic [PW-1:0]   shreg_q, shreg_d;
   logic [7:0]      tx_data_d;
   logic            tx_frame_d;
   logic            train_done_d;
   logic            transfer;

   // Ready is offered in IDLE, and in SEND only while the last byte is on the
   // wire, so a new word can follow with no gap.
   always_comb begin
      in_ready = 1'b0;
      if (enable) begin
         if (state_q == S_IDLE)
            in_ready = 1'b1;
         else if (state_q == S_SEND && bcnt_q == LAST)
            in_ready = 1'b1;
      end
   end

   assign transfer = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      bcnt_d       = bcnt_q;
      shreg_d      = shreg_q;
      tx_data_d    = IDLE_WORD;
      tx_frame_d   = 1'b0;
      train_done_d = train_done;
`ifdef OH_TXGEAR_TRAIN_EN
      tcnt_d       = tcnt_q;
`endif
      if (!enable) begin
         state_d      = S_OFF;
         bcnt_d       = '0;
         train_done_d = 1'b0;
      end else begin
         case (state_q)
            S_OFF: begin
`ifdef OH_TXGEAR_TRAIN_EN
               // The entry edge still shows IDLE_WORD; training bytes start
               // on the following edge.
               state_d      = S_TRAIN;
               tcnt_d       = '0;
               train_done_d = 1'b0;
`else
               state_d      = S_IDLE;
               train_done_d = 1'b1;
`endif
            end
`ifdef OH_TXGEAR_TRAIN_EN
            S_TRAIN: begin
               if (tcnt_q == TC) begin
                  state_d      = S_IDLE;
                  train_done_d = 1'b1;
               end else begin
                  tx_data_d = TRAIN_WORD;
                  tcnt_d    = tcnt_q + 8'd1;
               end
            end
`endif
            S_IDLE: begin
               if (transfer) begin
                  state_d    = S_SEND;
                  bcnt_d     = '0;
                  shreg_d    = in_data >> 8;
                  tx_data_d  = in_data[7:0];
                  tx_frame_d = 1'b1;
               end
            end
            S_SEND: begin
               if (bcnt_q != LAST) begin
                  bcnt_d     = bcnt_q + BW'(1);
                  shreg_d    = shreg_q >> 8;
                  tx_data_d  = shreg_q[7:0];
                  tx_frame_d = 1'b1;
               end else if (transfer) begin
                  bcnt_d     = '0;
                  shreg_d    = in_data >> 8;
                  tx_data_d  = in_data[7:0];
                  tx_frame_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d      = S_OFF;
               train_done_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= S_OFF;
         bcnt_q     <= '0;
         shreg_q    <= '0;
         tx_data    <= 8'h00;
         tx_frame   <= 1'b0;
         train_done <= 1'b0;
`ifdef OH_TXGEAR_TRAIN_EN
         tcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         shreg_q    <= shreg_d;
         tx_data    <= tx_data_d;
         tx_frame   <= tx_frame_d;
         train_done <= train_done_d;
`ifdef OH_TXGEAR_TRAIN_EN
         tcnt_q     <= tcnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_oh_txgear.sv
// tb/tb_oh_txgear.sv - directed self-checking bench for oh_txgear

module tb_oh_txgear;

   logic        clk;
   logic        nreset;

   logic        en_a, v_a;
   logic [31:0] d_a;
   logic        rdy_a, fr_a, td_a;
   logic [7:0]  tx_a;

   logic        en_b, v_b;
   logic [7:0]  d_b;
   logic        rdy_b, fr_b, td_b;
   logic [7:0]  tx_b;

   int n_checks = 0;
   int n_errors = 0;

   logic        sel;
   wire  [7:0]  tx_s  = sel ? tx_b  : tx_a;
   wire         fr_s  = sel ? fr_b  : fr_a;
   wire         td_s  = sel ? td_b  : td_a;
   wire         rdy_s = sel ? rdy_b : rdy_a;

   oh_txgear #(.PW(32), .TRAIN_CYCLES(4), .TRAIN_WORD(8'hA5), .IDLE_WORD(8'h00)) u_dut_a (
      .clk        (clk),
      .nreset     (nreset),
      .enable     (en_a),
      .in_valid   (v_a),
      .in_data    (d_a),
      .in_ready   (rdy_a),
      .tx_data    (tx_a),
      .tx_frame   (fr_a),
      .train_done (td_a)
   );

   oh_txgear #(.PW(8), .TRAIN_CYCLES(4), .TRAIN_WORD(8'hA5), .IDLE_WORD(8'h00)) u_dut_b (
      .clk        (clk),
      .nreset     (nreset),
      .enable     (en_b),
      .in_valid   (v_b),
      .in_data    (d_b),
      .in_ready   (rdy_b),
      .tx_data    (tx_b),
      .tx_frame   (fr_b),
      .train_done (td_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] tx, input logic fr,
                            input logic td, input logic rdy);
      check({tag, "_tx"},  {24'h0, tx_s}, {24'h0, tx});
      check({tag, "_fr"},  {31'h0, fr_s}, {31'h0, fr});
      check({tag, "_td"},  {31'h0, td_s}, {31'h0, td});
      check({tag, "_rdy"}, {31'h0, rdy_s}, {31'h0, rdy});
   endtask

   task automatic bring_up(input logic b);
      sel = b;
      if (b) en_b = 1'b1;
      else   en_a = 1'b1;
      step();
`ifdef OH_TXGEAR_TRAIN_EN
      check_out("train_entry", 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_out("train", 8'hA5, 1'b0, 1'b0, 1'b0);
      end
      step();
`endif
      check_out("link_up", 8'h00, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      sel    = 1'b0;
      nreset = 1'b0;
      en_a = 1'b0; v_a = 1'b0; d_a = 32'h0;
      en_b = 1'b0; v_b = 1'b0; d_b = 8'h0;

      step();
      step();
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      nreset = 1'b1;
      step();
      check_out("off", 8'h00, 1'b0, 1'b0, 1'b0);

      bring_up(1'b0);

      // single word
      v_a = 1'b1; d_a = 32'h44332211;
      step();
      check_out("single_b0", 8'h11, 1'b1, 1'b1, 1'b0);
      v_a = 1'b0; d_a = 32'hDEADBEEF;
      step();
      check_out("single_b1", 8'h22, 1'b1, 1'b1, 1'b0);
      step();
      check_out("single_b2", 8'h33, 1'b1, 1'b1, 1'b0);
      step();
      check_out("single_b3", 8'h44, 1'b1, 1'b1, 1'b1);
      step();
      check_out("single_idle", 8'h00, 1'b0, 1'b1, 1'b1);

      // back-to-back words, in_valid held high
      v_a = 1'b1; d_a = 32'h04030201;
      for (int i = 0; i < 8; i++) begin
         step();
         check_out("b2b", 8'(i + 1), 1'b1, 1'b1, (i % 4) == 3);
         if (i == 0) d_a = 32'h08070605;
         if (i == 4) v_a = 1'b0;
      end
      step();
      check_out("b2b_idle", 8'h00, 1'b0, 1'b1, 1'b1);

      // enable dropped after byte 1
      v_a = 1'b1; d_a = 32'hDDCCBBAA;
      step();
      check_out("drop_b0", 8'hAA, 1'b1, 1'b1, 1'b0);
      v_a = 1'b0;
      step();
      check_out("drop_b1", 8'hBB, 1'b1, 1'b1, 1'b0);
      en_a = 1'b0;
      #1;
      check("drop_rdy_comb", {31'h0, rdy_a}, 32'h0);
      step();
      check_out("drop_off", 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      check_out("drop_off2", 8'h00, 1'b0, 1'b0, 1'b0);
      bring_up(1'b0);

      // reset asserted in the middle of a word
      v_a = 1'b1; d_a = 32'h11223344;
      step();
      check_out("rst_b0", 8'h44, 1'b1, 1'b1, 1'b0);
      v_a = 1'b0;
      step();
      check_out("rst_b1", 8'h33, 1'b1, 1'b1, 1'b0);
      #2 nreset = 1'b0;
      #1;
      check_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      check_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      nreset = 1'b1;
      bring_up(1'b0);
      v_a = 1'b1; d_a = 32'hCAFEF00D;
      step();
      check_out("post_rst_b0", 8'h0D, 1'b1, 1'b1, 1'b0);
      v_a = 1'b0;

      // PW=8 instance: one byte per word, ready every SEND cycle
      bring_up(1'b1);
      v_b = 1'b1; d_b = 8'h5A;
      step();
      check_out("nb1_b0", 8'h5A, 1'b1, 1'b1, 1'b1);
      d_b = 8'hC3;
      step();
      check_out("nb1_b1", 8'hC3, 1'b1, 1'b1, 1'b1);
      v_b = 1'b0;
      step();
      check_out("nb1_idle", 8'h00, 1'b0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
